// File: rtl/fetch_pc_sel_ctrl_if.sv
// Signal bundle between the fetch next-PC controller and the FD/X pipeline stages.
interface fetch_pc_sel_ctrl_if;
  logic        stall_in;
  logic [31:0] fd_pc;
  logic        fd_is_branch;
  logic        fd_is_jal;
  logic [31:0] x_pc;
  logic        x_is_branch;
  logic        x_is_jalr;
  logic        x_br_taken;
  logic [2:0]  pc_sel;
  logic        br_pred_taken;
  logic        bp_enable;
  logic        flush_fd;
  logic        pc_en;
  logic        x_mispredict;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;

  modport master (
    output stall_in, fd_pc, fd_is_branch, fd_is_jal,
           x_pc, x_is_branch, x_is_jalr, x_br_taken,
    input  pc_sel, br_pred_taken, bp_enable, flush_fd, pc_en,
           x_mispredict, branch_count, mispredict_count
  );

  modport slave (
    input  stall_in, fd_pc, fd_is_branch, fd_is_jal,
           x_pc, x_is_branch, x_is_jalr, x_br_taken,
    output pc_sel, br_pred_taken, bp_enable, flush_fd, pc_en,
           x_mispredict, branch_count, mispredict_count
  );
endinterface

// File: rtl/fetch_pc_sel_ctrl.sv
// Fetch next-PC select controller: boot hold-off, X/FD redirect priority, 2-bit BHT, perf counters.
// Define BRANCH_PRED_EN to build the BHT predictor; otherwise branches are statically not-taken.
module fetch_pc_sel_ctrl #(
  parameter int unsigned BHT_ENTRIES = 64,
  parameter int unsigned BOOT_CYCLES = 2
) (
  input logic                 clk,
  input logic                 rst,
  fetch_pc_sel_ctrl_if.slave  bus
);
  localparam int unsigned IDX_W  = $clog2(BHT_ENTRIES);
  localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
  localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

  localparam logic [2:0] SEL_JALR = 3'd0;
  localparam logic [2:0] SEL_BR   = 3'd1;
  localparam logic [2:0] SEL_SEQ  = 3'd2;
  localparam logic [2:0] SEL_PRED = 3'd3;
  localparam logic [2:0] SEL_JAL  = 3'd4;

  typedef enum logic {BOOT, RUN} state_e;

  state_e            state_q, state_d;
  logic [BOOT_W-1:0] boot_cnt_q;
  logic              x_valid_q;
  logic              x_pred_q;
  logic [31:0]       branch_count_q;
  logic [31:0]       mispredict_count_q;

  logic [2:0]        pc_sel;
  logic              flush_fd;
  logic              br_pred_taken;
  logic              x_mispredict;
  logic              pc_en;
  logic              x_br_resolve;
  logic              fd_pred;

`ifdef BRANCH_PRED_EN
  logic [1:0]       bht_q [BHT_ENTRIES];
  logic [IDX_W-1:0] rd_idx;
  logic [IDX_W-1:0] wr_idx;

  assign rd_idx        = bus.fd_pc[IDX_W+1:2];
  assign wr_idx        = bus.x_pc[IDX_W+1:2];
  // Read is from the registered table, so a same-index update is not bypassed.
  assign fd_pred       = bht_q[rd_idx][1];
  assign bus.bp_enable = 1'b1;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BHT_ENTRIES; i++) bht_q[i] <= 2'b01;
    end else if (!bus.stall_in && x_br_resolve) begin
      if (bus.x_br_taken) begin
        if (bht_q[wr_idx] != 2'b11) bht_q[wr_idx] <= bht_q[wr_idx] + 2'b01;
      end else begin
        if (bht_q[wr_idx] != 2'b00) bht_q[wr_idx] <= bht_q[wr_idx] - 2'b01;
      end
    end
  end
`else
  assign fd_pred       = 1'b0;
  assign bus.bp_enable = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) state_q <= BOOT;
    else if (!bus.stall_in) state_q <= state_d;
  end

  // Next state and redirect decode; X-stage redirects outrank FD-stage ones.
  always_comb begin
    state_d       = state_q;
    pc_sel        = SEL_SEQ;
    flush_fd      = 1'b0;
    br_pred_taken = 1'b0;
    x_mispredict  = 1'b0;
    pc_en         = 1'b0;
    x_br_resolve  = 1'b0;
    case (state_q)
      BOOT: begin
        if (boot_cnt_q == BOOT_LAST) state_d = RUN;
      end
      RUN: begin
        pc_en = ~bus.stall_in;
        if (x_valid_q && bus.x_is_jalr) begin
          pc_sel   = SEL_JALR;
          flush_fd = 1'b1;
        end else if (x_valid_q && bus.x_is_branch) begin
          pc_sel       = SEL_BR;
          x_br_resolve = 1'b1;
          x_mispredict = bus.x_br_taken != x_pred_q;
          flush_fd     = x_mispredict;
        end else if (bus.fd_is_jal) begin
          pc_sel = SEL_JAL;
        end else if (bus.fd_is_branch) begin
          pc_sel        = SEL_PRED;
          br_pred_taken = fd_pred;
        end
      end
      default: state_d = BOOT;
    endcase
  end

  // Boot counter, X-stage tracking and performance counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      boot_cnt_q         <= '0;
      x_valid_q          <= 1'b0;
      x_pred_q           <= 1'b0;
      branch_count_q     <= '0;
      mispredict_count_q <= '0;
    end else if (!bus.stall_in) begin
      if (state_q == BOOT) begin
        x_valid_q <= 1'b0;
        x_pred_q  <= 1'b0;
        if (boot_cnt_q != BOOT_LAST) boot_cnt_q <= boot_cnt_q + BOOT_W'(1);
      end else begin
        x_valid_q <= ~flush_fd;
        x_pred_q  <= br_pred_taken;
        if (x_br_resolve) begin
          branch_count_q <= branch_count_q + 32'd1;
          if (x_mispredict) mispredict_count_q <= mispredict_count_q + 32'd1;
        end
      end
    end
  end

  assign bus.pc_sel           = pc_sel;
  assign bus.br_pred_taken    = br_pred_taken;
  assign bus.flush_fd         = flush_fd;
  assign bus.pc_en            = pc_en;
  assign bus.x_mispredict     = x_mispredict;
  assign bus.branch_count     = branch_count_q;
  assign bus.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_fetch_pc_sel_ctrl.sv
// Bench for fetch_pc_sel_ctrl: directed vector table, hand sequences, and random stimulus vs a reference model.
module tb_fetch_pc_sel_ctrl;
  localparam int unsigned BHT_ENTRIES = 64;
  localparam int unsigned BOOT_CYCLES = 2;
`ifdef BRANCH_PRED_EN
  localparam bit PRED_EN = 1'b1;
`else
  localparam bit PRED_EN = 1'b0;
`endif
  localparam logic [31:0] P = 32'h4000_0010;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  fetch_pc_sel_ctrl_if bus ();

  fetch_pc_sel_ctrl #(.BHT_ENTRIES(BHT_ENTRIES), .BOOT_CYCLES(BOOT_CYCLES)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic        rst, stall;
    logic [31:0] fd_pc;
    logic        fd_br, fd_jal;
    logic [31:0] x_pc;
    logic        x_br, x_jalr, x_taken;
  } stim_t;

  typedef struct {
    stim_t      s;
    logic [2:0] sel;
    logic       en, flush, mp;
  } vec_t;

  int n_tests = 0;
  int n_fail  = 0;

  // Reference model state: boot progress, X-stage slot, counters, table of 2-bit counters.
  int          m_boot;
  bit          m_run, m_xv, m_xp;
  int unsigned m_bc, m_mc;
  int          m_bht [BHT_ENTRIES];
  logic [2:0]  e_sel;
  bit          e_en, e_flush, e_pred, e_mp, e_resolve;
  stim_t       cur;

  function automatic int idx(logic [31:0] p);
    return int'((p >> 2) % BHT_ENTRIES);
  endfunction

  function automatic stim_t st(logic fd_br, logic fd_jal, logic [31:0] fd_pc,
                               logic x_br, logic x_jalr, logic x_taken,
                               logic [31:0] x_pc, logic stall, logic r);
    stim_t s;
    s.rst = r; s.stall = stall; s.fd_pc = fd_pc; s.fd_br = fd_br; s.fd_jal = fd_jal;
    s.x_pc = x_pc; s.x_br = x_br; s.x_jalr = x_jalr; s.x_taken = x_taken;
    return s;
  endfunction

  function automatic vec_t mk(logic r, logic stall, logic fd_br, logic fd_jal,
                              logic x_br, logic x_jalr, logic x_taken,
                              logic [2:0] sel, logic en, logic flush, logic mp);
    vec_t v;
    v.s = st(fd_br, fd_jal, 32'h0000_0100, x_br, x_jalr, x_taken, 32'h0000_0200, stall, r);
    v.sel = sel; v.en = en; v.flush = flush; v.mp = mp;
    return v;
  endfunction

  function automatic void model_reset();
    m_boot = 0; m_run = 0; m_xv = 0; m_xp = 0; m_bc = 0; m_mc = 0;
    for (int i = 0; i < BHT_ENTRIES; i++) m_bht[i] = 1;
  endfunction

  function automatic void model_eval(stim_t s);
    e_sel = 3'd2; e_en = 0; e_flush = 0; e_pred = 0; e_mp = 0; e_resolve = 0;
    if (m_run) begin
      e_en = !s.stall;
      if (m_xv && s.x_jalr) begin
        e_sel = 3'd0; e_flush = 1;
      end else if (m_xv && s.x_br) begin
        e_sel = 3'd1; e_resolve = 1; e_mp = (s.x_taken != m_xp); e_flush = e_mp;
      end else if (s.fd_jal) begin
        e_sel = 3'd4;
      end else if (s.fd_br) begin
        e_sel = 3'd3; e_pred = PRED_EN && (m_bht[idx(s.fd_pc)] >= 2);
      end
    end
  endfunction

  function automatic void model_update(stim_t s);
    int i;
    if (s.rst) begin
      model_reset();
    end else if (!s.stall) begin
      if (!m_run) begin
        m_xv = 0; m_xp = 0; m_boot++;
        if (m_boot >= BOOT_CYCLES) m_run = 1;
      end else begin
        if (e_resolve) begin
          i = idx(s.x_pc);
          m_bc++;
          if (e_mp) m_mc++;
          if (s.x_taken) m_bht[i] = (m_bht[i] < 3) ? m_bht[i] + 1 : 3;
          else           m_bht[i] = (m_bht[i] > 0) ? m_bht[i] - 1 : 0;
        end
        m_xv = !e_flush; m_xp = e_pred;
      end
    end
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at t=%0t: got %0h, expected %0h", nm, $time, act, exp);
    end
  endtask

  task automatic apply(input stim_t s);
    cur = s;
    rst              = s.rst;
    bus.stall_in     = s.stall;
    bus.fd_pc        = s.fd_pc;
    bus.fd_is_branch = s.fd_br;
    bus.fd_is_jal    = s.fd_jal;
    bus.x_pc         = s.x_pc;
    bus.x_is_branch  = s.x_br;
    bus.x_is_jalr    = s.x_jalr;
    bus.x_br_taken   = s.x_taken;
    #2;
  endtask

  task automatic check_model();
    model_eval(cur);
    chk("model_pc_sel",        32'(bus.pc_sel),        32'(e_sel));
    chk("model_pc_en",         32'(bus.pc_en),         32'(e_en));
    chk("model_flush_fd",      32'(bus.flush_fd),      32'(e_flush));
    chk("model_br_pred_taken", 32'(bus.br_pred_taken), 32'(e_pred));
    chk("model_x_mispredict",  32'(bus.x_mispredict),  32'(e_mp));
    chk("model_bp_enable",     32'(bus.bp_enable),     32'(PRED_EN));
    chk("model_branch_count",  bus.branch_count,       m_bc);
    chk("model_mispred_count", bus.mispredict_count,   m_mc);
  endtask

  task automatic advance();
    @(posedge clk);
    model_update(cur);
    @(negedge clk);
  endtask

  task automatic cyc(input stim_t s);
    apply(s);
    check_model();
    advance();
  endtask

  function automatic logic [31:0] rand_pc();
    case ($urandom_range(0, 3))
      0:       return P;
      1:       return P + 32'd4;
      2:       return P + 32'h100;
      default: return {$urandom()} & 32'hFFFF_FFFC;
    endcase
  endfunction

  vec_t vecs [16];
  stim_t idle_s, rst_s;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle_s = st(0, 0, 32'h100, 0, 0, 0, 32'h200, 0, 0);
    rst_s  = st(0, 0, 32'h100, 0, 0, 0, 32'h200, 0, 1);

    // Columns: rst stall fd_br fd_jal x_br x_jalr x_taken | pc_sel pc_en flush mispredict
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0);
    vecs[1]  = mk(1, 0, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0);
    vecs[2]  = mk(1, 0, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0);
    vecs[3]  = mk(0, 0, 0, 0, 0, 0, 0, 3'd2, 0, 0, 0);
    vecs[4]  = mk(0, 0, 0, 1, 0, 1, 0, 3'd2, 0, 0, 0);
    vecs[5]  = mk(0, 0, 0, 0, 0, 0, 0, 3'd2, 1, 0, 0);
    vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 3'd2, 1, 0, 0);
    vecs[7]  = mk(0, 0, 0, 1, 0, 0, 0, 3'd4, 1, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 0, 1, 0, 3'd0, 1, 1, 0);
    vecs[9]  = mk(0, 0, 0, 1, 0, 1, 0, 3'd4, 1, 0, 0);
    vecs[10] = mk(0, 0, 1, 0, 1, 0, 1, 3'd1, 1, 1, 1);
    vecs[11] = mk(0, 0, 0, 0, 1, 0, 1, 3'd2, 1, 0, 0);
    vecs[12] = mk(0, 0, 0, 0, 1, 0, 0, 3'd1, 1, 0, 0);
    vecs[13] = mk(0, 1, 0, 1, 0, 1, 0, 3'd0, 0, 1, 0);
    vecs[14] = mk(0, 0, 0, 1, 0, 1, 0, 3'd0, 1, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 0, 0, 0, 3'd2, 1, 0, 0);

    // Settle the DUT into a known state before any comparison.
    model_reset();
    apply(rst_s);
    @(posedge clk); @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      apply(vecs[i].s);
      chk($sformatf("vec%0d_pc_sel", i),   32'(bus.pc_sel),       32'(vecs[i].sel));
      chk($sformatf("vec%0d_pc_en", i),    32'(bus.pc_en),        32'(vecs[i].en));
      chk($sformatf("vec%0d_flush", i),    32'(bus.flush_fd),     32'(vecs[i].flush));
      chk($sformatf("vec%0d_mispred", i),  32'(bus.x_mispredict), 32'(vecs[i].mp));
      check_model();
      advance();
    end
    chk("vec_branch_count", bus.branch_count, 32'd2);
    chk("vec_mispred_count", bus.mispredict_count, 32'd1);

    // BHT training on one PC, then a mispredict and a stray X branch behind it.
    for (int i = 0; i < 3; i++) cyc(rst_s);
    for (int i = 0; i < BOOT_CYCLES; i++) cyc(idle_s);

    apply(st(1, 0, P, 0, 0, 0, 32'h200, 0, 0));
    chk("train_a_sel", 32'(bus.pc_sel), 32'd3);
    chk("train_a_pred", 32'(bus.br_pred_taken), 32'd0);
    check_model(); advance();
    apply(st(0, 0, 32'h100, 1, 0, 1, P, 0, 0));
    chk("train_b_mispred", 32'(bus.x_mispredict), 32'd1);
    check_model(); advance();
    cyc(idle_s);
    for (int k = 0; k < 2; k++) begin
      apply(st(1, 0, P, 0, 0, 0, 32'h200, 0, 0));
      chk("train_fd_pred", 32'(bus.br_pred_taken), 32'(PRED_EN));
      check_model(); advance();
      apply(st(0, 0, 32'h100, 1, 0, 1, P, 0, 0));
      chk("train_x_mispred", 32'(bus.x_mispredict), 32'(!PRED_EN));
      check_model(); advance();
    end
    apply(st(1, 0, P, 0, 0, 0, 32'h200, 0, 0));
    chk("train_h_sel", 32'(bus.pc_sel), 32'd3);
    chk("train_h_pred", 32'(bus.br_pred_taken), 32'(PRED_EN));
    chk("train_branch_count", bus.branch_count, 32'd3);
    chk("train_mispred_count", bus.mispredict_count, PRED_EN ? 32'd1 : 32'd3);
    check_model(); advance();
    apply(st(0, 0, 32'h100, 1, 0, 0, P, 0, 0));
    chk("flush_sel", 32'(bus.pc_sel), 32'd1);
    chk("flush_mispred", 32'(bus.x_mispredict), 32'(PRED_EN));
    chk("flush_flush", 32'(bus.flush_fd), 32'(PRED_EN));
    check_model(); advance();
    apply(st(0, 0, 32'h100, 1, 0, 1, P, 0, 0));
    chk("stray_sel", 32'(bus.pc_sel), PRED_EN ? 32'd2 : 32'd1);
    chk("stray_flush", 32'(bus.flush_fd), 32'(!PRED_EN));
    check_model(); advance();

    // Random traffic with aliasing PCs, stalls and occasional mid-run reset.
    for (int n = 0; n < 2000; n++) begin
      stim_t s;
      int xk;
      s.rst    = ($urandom_range(0, 199) == 0);
      s.stall  = ($urandom_range(0, 7) == 0);
      s.fd_pc  = rand_pc();
      s.x_pc   = ($urandom_range(0, 3) == 0) ? s.fd_pc : rand_pc();
      s.fd_br  = $urandom_range(0, 1) == 1;
      s.fd_jal = $urandom_range(0, 4) == 0;
      xk       = int'($urandom_range(0, 5));
      s.x_jalr = (xk == 0);
      s.x_br   = (xk >= 3);
      s.x_taken = $urandom_range(0, 1) == 1;
      cyc(s);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
